// File: rtl/cpu_pkg.sv
// Shared types and helpers for the CPU write-back stage.
package cpu_pkg;

    typedef struct packed {
        logic [4:0]  reg_d;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bypass the in-flight write onto a read operand; r0 is hardwired and never forwarded.
    function automatic logic [31:0] forward_operand(
        input logic        wr_en,
        input logic [4:0]  wr_reg,
        input logic [31:0] wr_data,
        input logic [4:0]  rd_reg,
        input logic [31:0] rf_data
    );
        return (wr_en && (wr_reg == rd_reg) && (rd_reg != REG_ZERO)) ? wr_data : rf_data;
    endfunction

endpackage

// File: rtl/cpu_writeback_if.sv
// Bundle of execute, multi-cycle, decode-read and register-file write signals around write-back.
interface cpu_writeback_if;

    logic        p3_write_en;
    logic [4:0]  p3_reg_d;
    logic [31:0] p3_data;

    logic        mc_issue;
    logic [4:0]  mc_issue_reg_d;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_reg_d;
    logic [31:0] mc_data;

    logic [4:0]  p2_reg_a;
    logic [4:0]  p2_reg_b;
    logic [31:0] p2_rf_data_a;
    logic [31:0] p2_rf_data_b;
    logic [31:0] p2_data_a;
    logic [31:0] p2_data_b;
    logic        p2_stall;

    logic        p4_write_en;
    logic [4:0]  p4_reg_d;
    logic [31:0] p4_reg_data_d;

    modport master (
        output p3_write_en, p3_reg_d, p3_data,
        output mc_issue, mc_issue_reg_d, mc_valid, mc_reg_d, mc_data,
        input  mc_ready,
        output p2_reg_a, p2_reg_b, p2_rf_data_a, p2_rf_data_b,
        input  p2_data_a, p2_data_b, p2_stall,
        input  p4_write_en, p4_reg_d, p4_reg_data_d
    );

    modport slave (
        input  p3_write_en, p3_reg_d, p3_data,
        input  mc_issue, mc_issue_reg_d, mc_valid, mc_reg_d, mc_data,
        output mc_ready,
        input  p2_reg_a, p2_reg_b, p2_rf_data_a, p2_rf_data_b,
        output p2_data_a, p2_data_b, p2_stall,
        output p4_write_en, p4_reg_d, p4_reg_data_d
    );

endinterface

// File: rtl/cpu_wb_fifo.sv
// Small synchronous FIFO buffering multi-cycle results until the write port is free.
module cpu_wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/cpu_writeback.sv
// Write-back stage: arbitrates execute and multi-cycle results onto the register-file port,
// tracks pending multi-cycle destinations and forwards the in-flight write to decode.
module cpu_writeback
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset,
    cpu_writeback_if.slave bus
);

    wb_entry_t   push_entry;
    wb_entry_t   fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    logic [31:0] pending;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    logic        p4_write_en;
    logic [4:0]  p4_reg_d;
    logic [31:0] p4_reg_data_d;

    assign push_entry  = '{reg_d: bus.mc_reg_d, data: bus.mc_data};
    assign bus.mc_ready = !fifo_full;
    assign fifo_push   = bus.mc_valid && !fifo_full;
    // Execute results can never be stalled, so the buffer only drains on idle cycles.
    assign fifo_pop    = !bus.p3_write_en && !fifo_empty;

    cpu_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p4_write_en   <= 1'b0;
            p4_reg_d      <= '0;
            p4_reg_data_d <= '0;
        end else if (bus.p3_write_en) begin
            p4_write_en   <= (bus.p3_reg_d != REG_ZERO);
            p4_reg_d      <= bus.p3_reg_d;
            p4_reg_data_d <= bus.p3_data;
        end else if (fifo_pop) begin
            p4_write_en   <= (fifo_head.reg_d != REG_ZERO);
            p4_reg_d      <= fifo_head.reg_d;
            p4_reg_data_d <= fifo_head.data;
        end else begin
            p4_write_en   <= 1'b0;
        end
    end

    // Set is applied after clear so a re-issue to a reg retiring this cycle stays pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.mc_issue && (bus.mc_issue_reg_d != REG_ZERO)) set_mask[bus.mc_issue_reg_d] = 1'b1;
        if (fifo_pop) clr_mask[fifo_head.reg_d] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign bus.p2_stall = ((bus.p2_reg_a != REG_ZERO) && pending[bus.p2_reg_a])
                       || ((bus.p2_reg_b != REG_ZERO) && pending[bus.p2_reg_b]);

    assign bus.p2_data_a = forward_operand(p4_write_en, p4_reg_d, p4_reg_data_d,
                                           bus.p2_reg_a, bus.p2_rf_data_a);
    assign bus.p2_data_b = forward_operand(p4_write_en, p4_reg_d, p4_reg_data_d,
                                           bus.p2_reg_b, bus.p2_rf_data_b);

    assign bus.p4_write_en   = p4_write_en;
    assign bus.p4_reg_d      = p4_reg_d;
    assign bus.p4_reg_data_d = p4_reg_data_d;

    a_single_outstanding: assert property (@(posedge clock) disable iff (reset)
        (bus.mc_issue && (bus.mc_issue_reg_d != REG_ZERO))
            |-> (!pending[bus.mc_issue_reg_d] || clr_mask[bus.mc_issue_reg_d]));

endmodule
